// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if: display bus between a scan controller and its user.
//   master : drives enable, digit nibbles and decimal-point mask; observes
//            the cathode/anode drive, slot index and frame pulse.
//   slave  : the scan controller side (ssd_scan_ctrl).
interface ssd_scan_ctrl_if;
  logic        ssd_scan_ctrl_en;
  logic [31:0] ssd_scan_ctrl_digits;
  logic [7:0]  ssd_scan_ctrl_dp_mask;
  logic [6:0]  ssd_scan_ctrl_cc;
  logic        ssd_scan_ctrl_odp;
  logic [7:0]  ssd_scan_ctrl_an;
  logic [2:0]  ssd_scan_ctrl_digit_idx;
  logic        ssd_scan_ctrl_frame_done;

  modport master (
    output ssd_scan_ctrl_en, ssd_scan_ctrl_digits, ssd_scan_ctrl_dp_mask,
    input  ssd_scan_ctrl_cc, ssd_scan_ctrl_odp, ssd_scan_ctrl_an,
           ssd_scan_ctrl_digit_idx, ssd_scan_ctrl_frame_done
  );

  modport slave (
    input  ssd_scan_ctrl_en, ssd_scan_ctrl_digits, ssd_scan_ctrl_dp_mask,
    output ssd_scan_ctrl_cc, ssd_scan_ctrl_odp, ssd_scan_ctrl_an,
           ssd_scan_ctrl_digit_idx, ssd_scan_ctrl_frame_done
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 8-digit multiplexed seven-segment scan controller.
// Each digit slot lasts REFRESH_DIV cycles, the first BLANK_CYCLES of which
// keep all anodes off to avoid ghosting. Digits and decimal points are
// snapshotted at frame start so mid-frame input changes never tear a frame.
// Ports:
//   ssd_scan_ctrl_clk : clock, rising edge
//   ssd_scan_ctrl_rst : synchronous active-high reset
//   bus (slave)       : en, digits[31:0], dp_mask[7:0] in;
//                       cc[6:0] {g..a}, odp, an[7:0] (all active-low),
//                       digit_idx[2:0], frame_done out (all registered)
// Optional build macro: SSD_SCAN_CTRL_LZ_EN enables leading-zero suppression.
module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic           ssd_scan_ctrl_clk,
  input logic           ssd_scan_ctrl_rst,
  ssd_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       cc_q, cc_d;
  logic             odp_q, odp_d;
  logic [7:0]       an_q, an_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [3:0]       nibble;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // State register; outputs are registered from the next-state decode so they
  // always reflect the registered state of the same cycle.
  always_ff @(posedge ssd_scan_ctrl_clk) begin
    if (ssd_scan_ctrl_rst) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      idx_q        <= 3'd0;
      snap_q       <= 32'd0;
      snap_dp_q    <= 8'd0;
      frame_done_q <= 1'b0;
      cc_q         <= 7'h7F;
      odp_q        <= 1'b1;
      an_q         <= 8'hFF;
      digit_idx_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      snap_dp_q    <= snap_dp_d;
      frame_done_q <= frame_done_d;
      cc_q         <= cc_d;
      odp_q        <= odp_d;
      an_q         <= an_d;
      digit_idx_q  <= digit_idx_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    snap_dp_d    = snap_dp_q;
    frame_done_d = 1'b0;
    an_d         = 8'hFF;
    cc_d         = 7'h7F;
    odp_d        = 1'b1;
    digit_idx_d  = 3'd0;
    nibble       = 4'h0;

    if (!bus.ssd_scan_ctrl_en) begin
      // Dropping enable aborts the frame silently
      state_d = ST_IDLE;
      slot_d  = '0;
      idx_d   = 3'd0;
    end else begin
      if (state_q == ST_IDLE) begin
        snap_d    = bus.ssd_scan_ctrl_digits;
        snap_dp_d = bus.ssd_scan_ctrl_dp_mask;
        slot_d    = '0;
        idx_d     = 3'd0;
      end else if (slot_q == CNT_W'(REFRESH_DIV - 1)) begin
        slot_d = '0;
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          // Frame boundary: pulse and take a fresh snapshot
          frame_done_d = 1'b1;
          snap_d       = bus.ssd_scan_ctrl_digits;
          snap_dp_d    = bus.ssd_scan_ctrl_dp_mask;
        end
      end else begin
        slot_d = slot_q + CNT_W'(1);
      end
      state_d = (slot_d < CNT_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
    end

    nibble = snap_d[{idx_d, 2'b00} +: 4];

    case (state_d)
      ST_BLANK: begin
        digit_idx_d = idx_d;
      end
      ST_DRIVE: begin
        digit_idx_d = idx_d;
        an_d        = ~(8'd1 << idx_d);
        cc_d        = hex_to_seg(nibble);
        odp_d       = ~snap_dp_d[idx_d];
`ifdef SSD_SCAN_CTRL_LZ_EN
        // Digit i>0 is dark when it and every higher nibble are zero
        if ((idx_d != 3'd0) && ((snap_d >> {idx_d, 2'b00}) == 32'd0)) begin
          cc_d = 7'h7F;
        end
`endif
      end
      default: begin
        digit_idx_d = 3'd0;
      end
    endcase
  end

  assign bus.ssd_scan_ctrl_cc         = cc_q;
  assign bus.ssd_scan_ctrl_odp        = odp_q;
  assign bus.ssd_scan_ctrl_an         = an_q;
  assign bus.ssd_scan_ctrl_digit_idx  = digit_idx_q;
  assign bus.ssd_scan_ctrl_frame_done = frame_done_q;

endmodule
